r5p_console: RTL and testbench
==============================

R5P_CONSOLE -- requirements
Module: r5p_console

Interface
REQ-001 The block SHALL have parameter DAW, default 16, bus address width.
REQ-002 The block SHALL have parameter DDW, default 32, bus data width (32 or 64).
REQ-003 The block SHALL have parameter DSW, default DDW/8, bus byte-select width.
REQ-004 The block SHALL have parameter FDP, default 16, TX FIFO depth (power of 2, 2..128).
REQ-005 The block SHALL have parameter BDR, default 16, clock cycles per serial bit (>=1).
REQ-006 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 The block SHALL have port bus_req, input, 1, bus transfer request.
REQ-009 The block SHALL have port bus_wen, input, 1, write enable (1 = write).
REQ-010 The block SHALL have port bus_adr, input, DAW, byte address; only bits [3:2] are decoded.
REQ-011 The block SHALL have port bus_sel, input, DSW, byte select.
REQ-012 The block SHALL have port bus_wdt, input, DDW, write data.
REQ-013 The block SHALL have port bus_rdt, output, DDW, read data.
REQ-014 The block SHALL have port bus_ack, output, 1, transfer acknowledge.
REQ-015 The block SHALL have port txd, output, 1, serial 8N1 transmit line (idle high).

Function
REQ-016 Register map by adr[3:2]: 0 TXDATA (W), 1 STATUS (R), 2 CTRL (R/W, macro only), 3 reserved (reads 0, writes ignored).
REQ-017 bus_ack SHALL equal bus_req combinationally, except a TXDATA write with sel[0]=1 while the FIFO is full SHALL hold bus_ack low (stall) until not full.
REQ-018 An acked TXDATA write with sel[0]=1 SHALL push wdt[7:0]; with sel[0]=0 it SHALL be acked without a push.
REQ-019 bus_rdt SHALL be valid combinationally in the ack cycle of a read, and 0 whenever no read is requested; TXDATA reads return 0.
REQ-020 STATUS: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bits[15:8] FIFO count, all other bits 0.
REQ-021 FIFO pointers SHALL be log2(FDP)+1 bits and wrap modulo 2*FDP; full/empty derive from the MSB comparison.
REQ-022 A push to a full FIFO SHALL be impossible (stalled), even if a pop occurs in the same cycle; push and pop in one cycle on a non-full, non-empty FIFO SHALL leave the count unchanged.
REQ-023 TX FSM states: IDLE, START, DATA, STOP; bit timer counts BDR cycles per state bit.
REQ-024 IDLE: if FIFO not empty, pop into shifter and enter START on the next edge; else stay, txd=1.
REQ-025 START drives txd=0 for BDR cycles; DATA drives 8 bits LSB first, BDR cycles each; STOP drives txd=1 for BDR cycles.
REQ-026 At the end of STOP, if FIFO is non-empty the block SHALL pop and enter START directly (no idle gap); else enter IDLE.
REQ-027 Frame length SHALL be exactly 10*BDR cycles; txd SHALL be registered (glitch-free).

Reset
REQ-028 While rst=0: FSM IDLE, FIFO empty (count 0), bit timer and bit counter 0, txd=1, CTRL=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately with txd=1 and discard FIFO contents.
REQ-030 Combinational outputs bus_ack and bus_rdt SHALL follow REQ-017/REQ-019 during reset, with STATUS reading empty=1.

Configuration
REQ-031 Macro R5P_CONSOLE_IRQ_EN, when defined, SHALL add output port irq (1 bit, reset 0) and the CTRL register (bit0 irq enable, other bits read 0).
REQ-032 With R5P_CONSOLE_IRQ_EN, irq SHALL be registered and equal CTRL[0] & FIFO empty & FSM IDLE, delayed one cycle.
REQ-033 Without R5P_CONSOLE_IRQ_EN, irq port and CTRL register SHALL not exist; address 2 behaves as reserved.

Verification
REQ-034 BDR=4: write 0x55 to TXDATA -> ack same cycle; txd shows 0,1,0,1,0,1,0,1,0,1 bit pattern, 4 cycles each, 40-cycle frame.
REQ-035 FDP=4, BDR=16: burst 6 writes -> first 5 acked without stall (one popped at once), 6th stalls until first frame ends; frames back-to-back with no idle cycles.
REQ-036 Read STATUS after reset -> 0x00000002; after 3 quick pushes with BDR=16 -> count field 2, busy=1.
REQ-037 Assert rst during DATA bit 3 -> txd=1 immediately, STATUS reads 0x00000002 after release, no further frame.
REQ-038 Write with sel=0b1110 to TXDATA -> acked, count unchanged, txd stays 1.
REQ-039 With R5P_CONSOLE_IRQ_EN: set CTRL=1, send one byte -> irq low during frame, high one cycle after return to IDLE; CTRL=0 -> irq low.

Source files
------------

// File: rtl/r5p_console.sv
// rtl/r5p_console.sv - bus-mapped console: TX FIFO feeding an 8N1 serial transmitter (optional irq/CTRL via R5P_CONSOLE_IRQ_EN)
module r5p_console #(
  parameter int DAW = 16,
  parameter int DDW = 32,
  parameter int DSW = DDW/8,
  parameter int FDP = 16,
  parameter int BDR = 16
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           bus_req,
  input  logic           bus_wen,
  input  logic [DAW-1:0] bus_adr,
  input  logic [DSW-1:0] bus_sel,
  input  logic [DDW-1:0] bus_wdt,
  output logic [DDW-1:0] bus_rdt,
  output logic           bus_ack,
  output logic           txd
`ifdef R5P_CONSOLE_IRQ_EN
  ,
  output logic           irq
`endif
);

  localparam int AW = $clog2(FDP);
  localparam int TW = (BDR > 1) ? $clog2(BDR) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FDP];
  logic [AW:0]   wp, rp, cnt;
  logic          full, empty, push, pop, push_req;
  state_t        state;
  logic [TW-1:0] tmr;
  logic [2:0]    bitn;
  logic [7:0]    shf;
  logic          bit_end, busy;
  logic [1:0]    rsel;
  logic [31:0]   status;
  logic          unused_bits;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign cnt   = wp - rp;
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);

  assign rsel     = bus_adr[3:2];
  assign push_req = bus_req & bus_wen & (rsel == 2'd0) & bus_sel[0];
  assign push     = push_req & ~full;
  assign bus_ack  = bus_req & ~(push_req & full);

  assign bit_end = (tmr == TW'(BDR-1));
  assign busy    = (state != IDLE);
  assign pop     = !empty && ((state == IDLE) || (state == STOP && bit_end));

  assign status = {16'd0, 8'(cnt), 5'd0, busy, empty, full};

  assign unused_bits = ^{bus_adr[DAW-1:4], bus_adr[1:0], bus_sel[DSW-1:1], bus_wdt[DDW-1:8]};

`ifdef R5P_CONSOLE_IRQ_EN
  logic ctrl_en;

  // CTRL register and irq: irq reflects "enabled and fully drained" one cycle late.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_en <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (bus_req && bus_wen && rsel == 2'd2 && bus_sel[0])
        ctrl_en <= bus_wdt[0];
      irq <= ctrl_en & empty & (state == IDLE);
    end
  end
`endif

  // Read mux: data only while a read is requested, zero otherwise.
  always_comb begin
    bus_rdt = '0;
    if (bus_req && !bus_wen) begin
      case (rsel)
        2'd1:    bus_rdt = DDW'(status);
`ifdef R5P_CONSOLE_IRQ_EN
        2'd2:    bus_rdt = DDW'(ctrl_en);
`endif
        default: bus_rdt = '0;
      endcase
    end
  end

  // FIFO storage has no reset; emptiness is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (push)
      mem[wp[AW-1:0]] <= bus_wdt[7:0];
  end

  // FIFO pointers; reset discards any queued bytes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  // Transmit FSM with registered txd; STOP chains straight into START when data waits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      tmr   <= '0;
      bitn  <= '0;
      shf   <= '0;
      txd   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tmr <= '0;
          if (!empty) begin
            shf   <= mem[rp[AW-1:0]];
            state <= START;
            txd   <= 1'b0;
          end else begin
            txd <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            tmr   <= '0;
            bitn  <= '0;
            state <= DATA;
            txd   <= shf[0];
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            tmr <= '0;
            if (bitn == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bitn <= bitn + 1'b1;
              shf  <= {1'b0, shf[7:1]};
              txd  <= shf[1];
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            tmr <= '0;
            if (!empty) begin
              shf   <= mem[rp[AW-1:0]];
              state <= START;
              txd   <= 1'b0;
            end else begin
              state <= IDLE;
              txd   <= 1'b1;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_r5p_console.sv
// tb/tb_r5p_console.sv - directed table-driven bench for r5p_console (FDP=4, BDR=4)
module tb_r5p_console;

  localparam int BDR = 4;
  localparam int FDP = 4;
  localparam int FRM = 10*BDR;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bus_req = 1'b0;
  logic        bus_wen = 1'b0;
  logic [15:0] bus_adr = '0;
  logic [3:0]  bus_sel = '0;
  logic [31:0] bus_wdt = '0;
  logic [31:0] bus_rdt;
  logic        bus_ack;
  logic        txd;
`ifdef R5P_CONSOLE_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        req;
    logic        wen;
    logic [15:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdt;
    logic        exp_ack;
    logic [31:0] exp_rdt;
  } vec_t;

  vec_t vecs [12];
  int   st [6];
  logic [7:0] bytes [6];
  logic [6*FRM-1:0] capv;

  always #5 clk = ~clk;

  r5p_console #(.DAW(16), .DDW(32), .DSW(4), .FDP(FDP), .BDR(BDR)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus_req (bus_req),
    .bus_wen (bus_wen),
    .bus_adr (bus_adr),
    .bus_sel (bus_sel),
    .bus_wdt (bus_wdt),
    .bus_rdt (bus_rdt),
    .bus_ack (bus_ack),
    .txd     (txd)
`ifdef R5P_CONSOLE_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_bus(input logic req, input logic wen, input logic [15:0] adr,
                         input logic [3:0] sel, input logic [31:0] wdt);
    bus_req = req; bus_wen = wen; bus_adr = adr; bus_sel = sel; bus_wdt = wdt;
  endtask

  task automatic idle_bus();
    set_bus(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
  endtask

  task automatic read_reg(input logic [15:0] adr, output logic [31:0] r);
    set_bus(1'b1, 1'b0, adr, 4'hF, 32'h0);
    #1;
    r = bus_rdt;
    @(posedge clk); #1;
    idle_bus();
  endtask

  task automatic write_wait(input logic [15:0] adr, input logic [31:0] d,
                            input logic [3:0] sel, output int stall);
    stall = 0;
    set_bus(1'b1, 1'b1, adr, sel, d);
    #1;
    while (!bus_ack && stall < 300) begin
      @(posedge clk); #2;
      stall++;
    end
    @(posedge clk); #1;
    idle_bus();
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  task automatic wait_idle(input string name);
    logic [31:0] r;
    int n;
    n = 0;
    read_reg(16'h4, r);
    while (r !== 32'h2 && n < 500) begin
      read_reg(16'h4, r);
      n++;
    end
    chk(name, r, 32'h2);
  endtask

  initial begin
    logic [31:0] r;
    int s, nerr, lows;

    vecs[0]  = '{1'b0, 1'b0, 16'h0004, 4'hF, 32'h0,  1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 16'h0004, 4'hF, 32'h0,  1'b1, 32'h2};
    vecs[2]  = '{1'b1, 1'b0, 16'h0000, 4'hF, 32'h0,  1'b1, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 16'h000C, 4'hF, 32'h0,  1'b1, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 16'h0008, 4'hF, 32'h0,  1'b1, 32'h0};
    vecs[5]  = '{1'b1, 1'b1, 16'h0000, 4'hE, 32'h41, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 16'h0004, 4'hF, 32'h0,  1'b1, 32'h2};
    vecs[7]  = '{1'b1, 1'b1, 16'h000C, 4'hF, 32'hFF, 1'b1, 32'h0};
    vecs[8]  = '{1'b1, 1'b1, 16'h0004, 4'hF, 32'hFF, 1'b1, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 16'h0014, 4'hF, 32'h0,  1'b1, 32'h2};
    vecs[10] = '{1'b0, 1'b1, 16'h0000, 4'h1, 32'h77, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 16'h0004, 4'hF, 32'h0,  1'b1, 32'h2};

    bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'h01;
    bytes[3] = 8'h80; bytes[4] = 8'hFF; bytes[5] = 8'h00;

    // reset state, including combinational bus behaviour while held in reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", {31'b0, txd}, 32'h1);
    chk("rst_ack_noreq", {31'b0, bus_ack}, 32'h0);
    chk("rst_rdt_noreq", bus_rdt, 32'h0);
    set_bus(1'b1, 1'b0, 16'h4, 4'hF, 32'h0);
    #1;
    chk("rst_ack_read", {31'b0, bus_ack}, 32'h1);
    chk("rst_status", bus_rdt, 32'h2);
    idle_bus();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // register-map vectors on an idle, empty block
    for (int i = 0; i < 12; i++) begin
      set_bus(vecs[i].req, vecs[i].wen, vecs[i].adr, vecs[i].sel, vecs[i].wdt);
      #1;
      chk($sformatf("vec%0d_ack", i), {31'b0, bus_ack}, {31'b0, vecs[i].exp_ack});
      chk($sformatf("vec%0d_rdt", i), bus_rdt, vecs[i].exp_rdt);
      @(posedge clk); #1;
      idle_bus();
    end
    repeat (4) @(posedge clk);
    #1;
    chk("nopush_txd_idle", {31'b0, txd}, 32'h1);

    // single 0x55 frame, sampled every cycle
    write_wait(16'h0, 32'h55, 4'h1, s);
    chk("w55_stall", s, 0);
    chk("w55_pre_txd", {31'b0, txd}, 32'h1);
    @(posedge clk); #1;
    nerr = 0;
    for (int i = 0; i < FRM; i++) begin
      if (txd !== frame_bit(8'h55, i / BDR)) nerr++;
      @(posedge clk); #1;
    end
    chk("frame55_bit_errors", nerr, 0);
    read_reg(16'h4, r);
    chk("frame55_status_after", r, 32'h2);

    // three quick pushes: one goes straight to the shifter
    write_wait(16'h0, 32'hA1, 4'h1, s);
    write_wait(16'h0, 32'hA2, 4'h1, s);
    write_wait(16'h0, 32'hA3, 4'h1, s);
    read_reg(16'h4, r);
    chk("quick3_status", r, 32'h0000_0204);
    wait_idle("quick3_drain");

    // burst of six into a four-deep FIFO: stall on the sixth, frames back to back
    fork
      begin
        int n;
        n = 0;
        while (txd !== 1'b0 && n < 100) begin
          @(posedge clk); #1;
          n++;
        end
        for (int i = 0; i < 6*FRM; i++) begin
          capv[i] = txd;
          @(posedge clk); #1;
        end
      end
      begin
        for (int k = 0; k < 6; k++) write_wait(16'h0, {24'h0, bytes[k]}, 4'h1, st[k]);
      end
    join
    for (int k = 0; k < 5; k++) chk($sformatf("burst_stall%0d", k), st[k], 0);
    chk("burst_stall5", st[5], 41 - FDP);
    nerr = 0;
    for (int i = 0; i < 6*FRM; i++)
      if (capv[i] !== frame_bit(bytes[i / FRM], (i % FRM) / BDR)) nerr++;
    chk("burst_stream_errors", nerr, 0);
    read_reg(16'h4, r);
    chk("burst_status_end", r, 32'h2);

    // reset in the middle of DATA bit 3 with more bytes queued
    write_wait(16'h0, 32'h00, 4'h1, s);
    write_wait(16'h0, 32'h00, 4'h1, s);
    write_wait(16'h0, 32'h00, 4'h1, s);
    repeat (16) @(posedge clk);
    #1;
    chk("midframe_txd", {31'b0, txd}, 32'h0);
    rst = 1'b0;
    #1;
    chk("abort_txd", {31'b0, txd}, 32'h1);
    set_bus(1'b1, 1'b0, 16'h4, 4'hF, 32'h0);
    #1;
    chk("abort_status_in_rst", bus_rdt, 32'h2);
    idle_bus();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    read_reg(16'h4, r);
    chk("abort_status_after", r, 32'h2);
    lows = 0;
    for (int i = 0; i < 3*FRM; i++) begin
      if (txd !== 1'b1) lows++;
      @(posedge clk); #1;
    end
    chk("abort_no_frame", lows, 0);

`ifdef R5P_CONSOLE_IRQ_EN
    chk("irq_off", {31'b0, irq}, 32'h0);
    write_wait(16'h8, 32'h1, 4'h1, s);
    @(posedge clk); #1;
    chk("irq_idle_on", {31'b0, irq}, 32'h1);
    read_reg(16'h8, r);
    chk("ctrl_read", r, 32'h1);
    write_wait(16'h0, 32'h33, 4'h1, s);
    @(posedge clk); #1;
    chk("irq_frame_start", {31'b0, irq}, 32'h0);
    repeat (39) @(posedge clk);
    #1;
    chk("irq_frame_stop", {31'b0, irq}, 32'h0);
    @(posedge clk); #1;
    chk("irq_idle_edge", {31'b0, irq}, 32'h0);
    @(posedge clk); #1;
    chk("irq_after_idle", {31'b0, irq}, 32'h1);
    write_wait(16'h8, 32'h0, 4'h1, s);
    @(posedge clk); #1;
    chk("irq_disabled", {31'b0, irq}, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
